// File: rtl/z_mul_arbiter_if.sv
// rtl/z_mul_arbiter_if.sv - Request/response and multiplier signal bundle for z_mul_arbiter
// The master side is the environment (clients plus the shared multiplier); the slave side is the arbiter.
interface z_mul_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_oper1;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_oper2;
    logic [NUM_REQ-1:0]              rsp_valid;
    logic [NUM_REQ-1:0]              rsp_ready;
    logic [NUM_REQ*2*DATA_WIDTH-1:0] rsp_product;
    logic [DATA_WIDTH-1:0]           mul_oper1;
    logic [DATA_WIDTH-1:0]           mul_oper2;
    logic [2*DATA_WIDTH-1:0]         mul_product;
    logic                            busy;

    modport master (
        output req_valid, req_oper1, req_oper2, rsp_ready, mul_product,
        input  req_ready, rsp_valid, rsp_product, mul_oper1, mul_oper2, busy
    );

    modport slave (
        input  req_valid, req_oper1, req_oper2, rsp_ready, mul_product,
        output req_ready, rsp_valid, rsp_product, mul_oper1, mul_oper2, busy
    );
endinterface

// File: rtl/z_mul_arbiter.sv
// rtl/z_mul_arbiter.sv - Round-robin sharing of one fixed-latency multiplier among NUM_REQ requesters
// A tag shift register tracks which requester owns the product emerging from the multiplier.
module z_mul_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1
) (
    input  logic           z_clk,
    input  logic           z_rst,
    z_mul_arbiter_if.slave bus
);
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_DEPTH = MUL_LATENCY + 1;
    localparam int PW        = 2 * DATA_WIDTH;

    logic [IDX_W-1:0]      ptr;
    logic [NUM_REQ-1:0]    inflight;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [PW-1:0]         rsp_prod_q [NUM_REQ];
    logic [TAG_DEPTH-1:0]  tag_valid;
    logic [IDX_W-1:0]      tag_id [TAG_DEPTH];
    logic [DATA_WIDTH-1:0] oper1_q;
    logic [DATA_WIDTH-1:0] oper2_q;

    logic [NUM_REQ-1:0]    pending;
    logic [NUM_REQ-1:0]    elig;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [NUM_REQ-1:0]    cap_oh;
    logic [NUM_REQ-1:0]    ack_oh;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    assign pending = inflight | rsp_valid_q;
    assign elig    = bus.req_valid & ~pending;

    // Scan from the farthest offset down so the eligible index nearest ptr is written last.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            if (elig[wrap_idx(ptr, o)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(ptr, o);
            end
        end
    end

    assign grant_oh = (grant_found && !z_rst) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign cap_oh   = tag_valid[TAG_DEPTH-1] ? (NUM_REQ'(1) << tag_id[TAG_DEPTH-1]) : '0;
    assign ack_oh   = rsp_valid_q & bus.rsp_ready;

    always_ff @(posedge z_clk or posedge z_rst) begin
        if (z_rst) begin
            ptr         <= '0;
            inflight    <= '0;
            rsp_valid_q <= '0;
            tag_valid   <= '0;
            oper1_q     <= '0;
            oper2_q     <= '0;
            for (int i = 0; i < NUM_REQ; i++) rsp_prod_q[i] <= '0;
            for (int s = 0; s < TAG_DEPTH; s++) tag_id[s] <= '0;
        end else begin
            if (grant_found) begin
                oper1_q <= bus.req_oper1[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                oper2_q <= bus.req_oper2[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                ptr     <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            tag_valid[0] <= grant_found;
            tag_id[0]    <= grant_idx;
            for (int s = 1; s < TAG_DEPTH; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_id[s]    <= tag_id[s-1];
            end
            inflight    <= (inflight | grant_oh) & ~cap_oh;
            rsp_valid_q <= (rsp_valid_q & ~ack_oh) | cap_oh;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cap_oh[i]) rsp_prod_q[i] <= bus.mul_product;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign bus.rsp_product[gi*PW +: PW] = rsp_prod_q[gi];
        end
    endgenerate

    assign bus.req_ready = grant_oh;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.mul_oper1 = oper1_q;
    assign bus.mul_oper2 = oper2_q;
    assign bus.busy      = |pending;
endmodule
